axi_lite_slave_regs: RTL
========================

AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 Parameter BASE_ADDR, default 32'h4000_0000, base address of the 32-byte register window.
REQ-002 Parameter ID_VALUE, default 32'h5249_5343, constant returned by read-only register 7.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: aclk and areset_n.
REQ-004 aclk  input  1  clock; all state changes on its rising edge.
REQ-005 areset_n  input  1  asynchronous active-low reset.
REQ-006 awaddr  input  32  write address; awvalid input 1; awready output 1.
REQ-007 wdata  input  32  write data; wstrb input 4 byte enables; wvalid input 1; wready output 1.
REQ-008 bresp  output  2  write response; bvalid output 1; bready input 1.
REQ-009 araddr  input  32  read address; arvalid input 1; arready output 1.
REQ-010 rdata  output  32  read data; rresp output 2; rvalid output 1; rready input 1.
REQ-011 o_regs  output  256  registers 0..6 (reg n at bits 32n+31:32n) plus ID_VALUE at bits 255:224.

Function
REQ-012 Decode: address hits when addr[31:5]==BASE_ADDR[31:5]; index = addr[4:2]; addr[1:0] SHALL be ignored.
REQ-013 Write FSM states W_IDLE, W_WRITE, W_RESP; reset state W_IDLE.
REQ-014 W_IDLE: awready=1 while AW not yet captured; wready=1 while W not yet captured; AW and W are accepted independently, in either order or in the same cycle.
REQ-015 On the edge at which the second of AW/W is captured: W_IDLE -> W_WRITE; awready and wready SHALL be 0 in W_WRITE and W_RESP.
REQ-016 W_WRITE lasts exactly one cycle: on its edge, for a hit to index 0..6, each byte k with wstrb[k]=1 is written; transition to W_RESP with bvalid=1.
REQ-017 bresp: OKAY (2'b00) for hit index 0..6; SLVERR (2'b10) for a miss or index 7, with no register changed.
REQ-018 W_RESP: bvalid and bresp held stable until bready=1; on the handshake edge, bvalid falls and state -> W_IDLE with both capture flags cleared.
REQ-019 wstrb=4'b0000 to a valid index SHALL respond OKAY with no data change.
REQ-020 Read FSM states R_IDLE, R_DATA; reset state R_IDLE; arready=1 only in R_IDLE.
REQ-021 On the arvalid&arready edge: rdata loaded with the register value before that edge (ID_VALUE for index 7), rresp=OKAY on hit; on miss rdata=0 and rresp=SLVERR; rvalid=1; state -> R_DATA.
REQ-022 Read latency SHALL be one cycle from AR handshake to rvalid; rdata/rresp held stable until rready=1, then rvalid falls and state -> R_IDLE.
REQ-023 A read handshaking on the same edge as a W_WRITE commit to the same index SHALL return the pre-write value.
REQ-024 The read and write channels SHALL operate concurrently with one outstanding transaction each.
REQ-025 Throughput: minimum 3 cycles per write (capture, write, response with bready=1) and 2 cycles per read.

Reset
REQ-026 While areset_n=0: registers 0..6 = 0, rdata=0, bresp=0, rresp=0, bvalid=0, rvalid=0, awready=0, wready=0, arready=0, capture flags cleared, FSMs in idle states.
REQ-027 awready, wready and arready SHALL rise in the first cycle after reset release.
REQ-028 Assertion of areset_n mid-transaction SHALL abort the transaction immediately; a partial write SHALL not be committed.

Verification
REQ-029 AW 0x4000_0004 and W 0xDEAD_BEEF (wstrb 4'hF) in the same cycle, bready=1 -> bvalid 2 cycles after the handshake, bresp=00, o_regs[63:32]=0xDEAD_BEEF.
REQ-030 W 0x1122_3344 with wstrb 4'b0101 sent 3 cycles before AW 0x4000_0008 -> reg2=0x0022_0044 from 0; awready stays 1 until AW arrives.
REQ-031 Read 0x4000_001C -> rvalid one cycle after the handshake, rdata=0x5249_5343, rresp=00; write to 0x4000_001C -> bresp=10, o_regs unchanged.
REQ-032 Read 0x5000_0000 -> rdata=0, rresp=10; with rready held 0 for 5 cycles, rvalid/rdata stay stable and arready stays 0.
REQ-033 Write 0x4000_0000 with bready=0, then assert areset_n=0 in W_RESP -> bvalid=0, reg0=0; the next write completes normally.

Source files
------------

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave with a 32-byte register window.
// Registers 0..6 are read/write with byte strobes.
// Register 7 is a read-only ID constant.
// The write and read channels run independently, with one transaction outstanding on each.
//
// Write FSM
//   state   | meaning
//   W_IDLE  | accepting AW and W in any order; capture flags track which ones have arrived
//   W_WRITE | single cycle; commits the strobed bytes on a hit to index 0..6
//   W_RESP  | bvalid high with bresp held until bready
//
// Read FSM
//   state   | meaning
//   R_IDLE  | arready high; an AR handshake loads rdata/rresp
//   R_DATA  | rvalid high with rdata/rresp held until rready
module axi_lite_slave_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] ID_VALUE  = 32'h5249_5343
) (
  input  logic         aclk,
  input  logic         areset_n,
  input  logic [31:0]  awaddr,
  input  logic         awvalid,
  output logic         awready,
  input  logic [31:0]  wdata,
  input  logic [3:0]   wstrb,
  input  logic         wvalid,
  output logic         wready,
  output logic [1:0]   bresp,
  output logic         bvalid,
  input  logic         bready,
  input  logic [31:0]  araddr,
  input  logic         arvalid,
  output logic         arready,
  output logic [31:0]  rdata,
  output logic [1:0]   rresp,
  output logic         rvalid,
  input  logic         rready,
  output logic [255:0] o_regs
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t    w_state, w_state_n;
  r_state_t    r_state, r_state_n;

  logic        live;
  logic        aw_cap, aw_cap_n;
  logic        w_cap, w_cap_n;
  logic [29:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] regs [0:6];
  logic [1:0]  bresp_q;

  logic        aw_hs, w_hs, ar_hs;
  logic        commit;
  logic        w_hit;
  logic [2:0]  w_idx;
  logic        r_hit;
  logic [2:0]  r_idx;
  logic [31:0] rd_val;

  // Address bits [1:0] carry no meaning for word-wide registers.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  // Ready outputs are held low until the first clock edge after reset is released.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) live <= 1'b0;
    else           live <= 1'b1;
  end

  // Handshake readies and the write-address decode.
  always_comb begin
    awready = live && (w_state == W_IDLE) && !aw_cap;
    wready  = live && (w_state == W_IDLE) && !w_cap;
    arready = live && (r_state == R_IDLE);
    aw_hs   = awvalid && awready;
    w_hs    = wvalid && wready;
    ar_hs   = arvalid && arready;
    w_idx   = awaddr_q[2:0];
    w_hit   = (awaddr_q[29:3] == BASE_ADDR[31:5]) && (w_idx != 3'd7);
    r_idx   = araddr[4:2];
    r_hit   = (araddr[31:5] == BASE_ADDR[31:5]);
  end

  // Write FSM: next state and capture flags.
  always_comb begin
    w_state_n = w_state;
    aw_cap_n  = aw_cap;
    w_cap_n   = w_cap;
    commit    = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_cap_n = aw_cap | aw_hs;
        w_cap_n  = w_cap | w_hs;
        if (aw_cap_n && w_cap_n) w_state_n = W_WRITE;
      end
      W_WRITE: begin
        commit    = 1'b1;
        w_state_n = W_RESP;
      end
      W_RESP: begin
        if (bready) begin
          w_state_n = W_IDLE;
          aw_cap_n  = 1'b0;
          w_cap_n   = 1'b0;
        end
      end
      default: begin
        w_state_n = W_IDLE;
        aw_cap_n  = 1'b0;
        w_cap_n   = 1'b0;
      end
    endcase
  end

  // Write FSM state and capture-flag registers.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_state <= W_IDLE;
      aw_cap  <= 1'b0;
      w_cap   <= 1'b0;
    end else begin
      w_state <= w_state_n;
      aw_cap  <= aw_cap_n;
      w_cap   <= w_cap_n;
    end
  end

  // Hold the captured address and data until the write commits.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs) awaddr_q <= awaddr[31:2];
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
    end
  end

  // Register file: the strobed byte lanes are written in the W_WRITE cycle.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int n = 0; n < 7; n++) regs[n] <= '0;
    end else if (commit && w_hit) begin
      for (int n = 0; n < 7; n++) begin
        if (w_idx == 3'(n)) begin
          for (int k = 0; k < 4; k++) begin
            if (wstrb_q[k]) regs[n][8*k +: 8] <= wdata_q[8*k +: 8];
          end
        end
      end
    end
  end

  // Write response code, fixed at commit and held through W_RESP.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)   bresp_q <= RESP_OKAY;
    else if (commit) bresp_q <= w_hit ? RESP_OKAY : RESP_SLVERR;
  end

  assign bvalid = (w_state == W_RESP);
  assign bresp  = bresp_q;

  // Read mux; index 7 returns the ID constant.
  always_comb begin
    rd_val = ID_VALUE;
    for (int n = 0; n < 7; n++) begin
      if (r_idx == 3'(n)) rd_val = regs[n];
    end
  end

  // Read FSM: next state.
  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_n = R_DATA;
      R_DATA:  if (rready) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_state <= R_IDLE;
    else           r_state <= r_state_n;
  end

  // Read data and response.
  // Because regs is read here with non-blocking semantics, a read on the same edge as a commit sees the pre-write value.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata <= r_hit ? rd_val : 32'h0;
      rresp <= r_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign rvalid = (r_state == R_DATA);

  // Flattened register view for the surrounding logic.
  always_comb begin
    o_regs = '0;
    for (int n = 0; n < 7; n++) o_regs[32*n +: 32] = regs[n];
    o_regs[255:224] = ID_VALUE;
  end

endmodule
